// File: rtl/ssd13xx_pkg.sv
// Shared opcodes, argument-count table and address-mode encodings for the
// SSD13xx-style graphics controller.
package ssd13xx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2
  } cmd_state_t;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'b00,
    MODE_VERT  = 2'b01,
    MODE_PAGE  = 2'b10
  } addr_mode_t;

  localparam logic [7:0] OP_MODE       = 8'h20;
  localparam logic [7:0] OP_COL_RANGE  = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE = 8'h22;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_OFFSET     = 8'hD3;
  localparam logic [7:0] OP_SEG_NORM   = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP  = 8'hA1;
  localparam logic [7:0] OP_ALL_OFF    = 8'hA4;
  localparam logic [7:0] OP_ALL_ON     = 8'hA5;
  localparam logic [7:0] OP_INV_OFF    = 8'hA6;
  localparam logic [7:0] OP_INV_ON     = 8'hA7;
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_COM_INC    = 8'hC0;
  localparam logic [7:0] OP_COM_DEC    = 8'hC8;

  // Prefix-matched single-byte opcode families
  localparam logic [3:0] OPHI_COL_LOW    = 4'h0;
  localparam logic [3:0] OPHI_COL_HIGH   = 4'h1;
  localparam logic [4:0] OPHI_PAGE_PTR   = 5'b10110;
  localparam logic [1:0] OPHI_START_LINE = 2'b01;

  localparam logic [7:0] RESET_CONTRAST = 8'h7F;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      8'h21, 8'h22, 8'h26, 8'h27, 8'h29, 8'h2A, 8'hA3:               arg_count = 2'd2;
      8'h20, 8'h81, 8'hD3, 8'hA8, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: arg_count = 2'd1;
      default:                                                        arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd13xx_gfx_ctrl_if.sv
// Byte-stream command/data handshake into the graphics controller.
interface ssd13xx_gfx_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_dc;
  logic [7:0] in_data;

  modport master (output in_valid, in_dc, in_data, input in_ready);
  modport slave  (input in_valid, in_dc, in_data, output in_ready);
endinterface

// File: rtl/ssd13xx_vram.sv
// Simple dual-port byte VRAM with registered read; a same-address
// read/write returns the old byte.
module ssd13xx_vram #(
  parameter int    DEPTH      = 1024,
  parameter int    AW         = 10,
  parameter string VRAM_STYLE = "block"
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  if (VRAM_STYLE == "block") begin : g_block
    (* ram_style = "block" *) logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ssd13xx_gfx_ctrl.sv
// SSD13xx-style command decoder, VRAM write pointer logic and raster
// pixel read path with remap, scroll and invert.
module ssd13xx_gfx_ctrl #(
  parameter  int    COLS       = 128,
  parameter  int    ROWS       = 64,
  parameter  string VRAM_STYLE = "block",
  localparam int    PAGES      = ROWS / 8,
  localparam int    CW         = $clog2(COLS),
  localparam int    RW         = $clog2(ROWS),
  localparam int    PW         = $clog2(PAGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd13xx_gfx_ctrl_if.slave    bus,
  input  logic [CW-1:0]        rd_col,
  input  logic [RW-1:0]        rd_row,
  output logic                 rd_pixel,
  output logic                 disp_on,
  output logic [7:0]           contrast
);
  import ssd13xx_pkg::*;

  cmd_state_t    state;
  addr_mode_t    mode;
  logic [7:0]    opcode;
  logic [CW-1:0] arg1;
  logic [CW-1:0] col_ptr, col_start, col_end;
  logic [PW-1:0] page_ptr, page_start, page_end;
  logic [RW-1:0] start_line, offset;
  logic          seg_remap, com_dec, invert, all_on;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          accept;

  logic [CW-1:0] phys_col;
  logic [RW-1:0] virt_row, phys_row;
  logic [7:0]    rdata;
  logic [2:0]    bit_sel;
  logic          pix_en, pix_all, pix_inv;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      opcode       <= '0;
      arg1         <= '0;
      bus.in_ready <= 1'b0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      col_ptr      <= '0;
      col_start    <= '0;
      col_end      <= CW'(COLS - 1);
      page_ptr     <= '0;
      page_start   <= '0;
      page_end     <= PW'(PAGES - 1);
      mode         <= MODE_PAGE;
      disp_on      <= 1'b0;
      contrast     <= RESET_CONTRAST;
      start_line   <= '0;
      offset       <= '0;
      seg_remap    <= 1'b0;
      com_dec      <= 1'b0;
      invert       <= 1'b0;
      all_on       <= 1'b0;
    end else begin
      bus.in_ready <= ~accept;
      wr_en        <= 1'b0;

      // Pointer advance happens in the write cycle, when in_ready is low,
      // so it never collides with a pointer-setting command.
      if (wr_en) begin
        case (mode)
          MODE_HORIZ:
            if (col_ptr == col_end) begin
              col_ptr  <= col_start;
              page_ptr <= (page_ptr == page_end) ? page_start : page_ptr + 1'b1;
            end else begin
              col_ptr <= col_ptr + 1'b1;
            end
          MODE_VERT:
            if (page_ptr == page_end) begin
              page_ptr <= page_start;
              col_ptr  <= (col_ptr == col_end) ? col_start : col_ptr + 1'b1;
            end else begin
              page_ptr <= page_ptr + 1'b1;
            end
          default: col_ptr <= col_ptr + 1'b1;
        endcase
      end

      if (accept) begin
        if (bus.in_dc) begin
          state   <= ST_IDLE;
          wr_en   <= 1'b1;
          wr_data <= bus.in_data;
        end else begin
          case (state)
            ST_IDLE: begin
              opcode <= bus.in_data;
              if (arg_count(bus.in_data) != 2'd0) begin
                state <= ST_ARG1;
              end else if (bus.in_data[7:4] == OPHI_COL_LOW) begin
                col_ptr <= CW'({4'(col_ptr >> 4), bus.in_data[3:0]});
              end else if (bus.in_data[7:4] == OPHI_COL_HIGH) begin
                col_ptr <= CW'({bus.in_data[3:0], 4'(col_ptr)});
              end else if (bus.in_data[7:3] == OPHI_PAGE_PTR) begin
                page_ptr <= bus.in_data[PW-1:0];
              end else if (bus.in_data[7:6] == OPHI_START_LINE) begin
                start_line <= bus.in_data[RW-1:0];
              end else begin
                case (bus.in_data)
                  OP_SEG_NORM, OP_SEG_REMAP: seg_remap <= bus.in_data[0];
                  OP_ALL_OFF,  OP_ALL_ON:    all_on    <= bus.in_data[0];
                  OP_INV_OFF,  OP_INV_ON:    invert    <= bus.in_data[0];
                  OP_DISP_OFF, OP_DISP_ON:   disp_on   <= bus.in_data[0];
                  OP_COM_INC,  OP_COM_DEC:   com_dec   <= bus.in_data[3];
                  default: ;
                endcase
              end
            end
            ST_ARG1: begin
              if (arg_count(opcode) == 2'd2) begin
                arg1  <= bus.in_data[CW-1:0];
                state <= ST_ARG2;
              end else begin
                state <= ST_IDLE;
                case (opcode)
                  OP_MODE:
                    if (bus.in_data[1:0] != 2'b11) mode <= addr_mode_t'(bus.in_data[1:0]);
                  OP_CONTRAST: contrast <= bus.in_data;
                  OP_OFFSET:   offset   <= bus.in_data[RW-1:0];
                  default: ;
                endcase
              end
            end
            ST_ARG2: begin
              state <= ST_IDLE;
              case (opcode)
                OP_COL_RANGE: begin
                  col_start <= arg1;
                  col_end   <= bus.in_data[CW-1:0];
                  col_ptr   <= arg1;
                end
                OP_PAGE_RANGE: begin
                  page_start <= arg1[PW-1:0];
                  page_end   <= bus.in_data[PW-1:0];
                  page_ptr   <= arg1[PW-1:0];
                end
                default: ;
              endcase
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Power-of-two geometry: mirroring is a bitwise invert, mod ROWS is truncation
  assign phys_col = seg_remap ? ~rd_col : rd_col;
  assign virt_row = rd_row + start_line + offset;
  assign phys_row = com_dec ? ~virt_row : virt_row;

  ssd13xx_vram #(
    .DEPTH      (COLS * PAGES),
    .AW         (PW + CW),
    .VRAM_STYLE (VRAM_STYLE)
  ) u_vram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({page_ptr, col_ptr}),
    .wdata (wr_data),
    .raddr ({phys_row[RW-1:3], phys_col}),
    .rdata (rdata)
  );

  // Display flags are captured alongside the VRAM read so they match its latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_sel <= '0;
      pix_en  <= 1'b0;
      pix_all <= 1'b0;
      pix_inv <= 1'b0;
    end else begin
      bit_sel <= phys_row[2:0];
      pix_en  <= disp_on;
      pix_all <= all_on;
      pix_inv <= invert;
    end
  end

  assign rd_pixel = pix_en & (pix_all | (rdata[bit_sel] ^ pix_inv));

endmodule

// File: tb/tb_ssd13xx_gfx_ctrl.sv
// Self-checking bench: directed command/data sequences against a behavioural
// model of the controller's registers and VRAM.
module tb_ssd13xx_gfx_ctrl;

  localparam int COLS  = 128;
  localparam int ROWS  = 64;
  localparam int PAGES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rd_col = '0;
  logic [5:0] rd_row = '0;
  logic       rd_pixel;
  logic       disp_on;
  logic [7:0] contrast;

  ssd13xx_gfx_ctrl_if bus ();

  ssd13xx_gfx_ctrl #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .VRAM_STYLE ("block")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rd_col   (rd_col),
    .rd_row   (rd_row),
    .rd_pixel (rd_pixel),
    .disp_on  (disp_on),
    .contrast (contrast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rd_check_en = 1'b0;

  // Behavioural model state
  logic [7:0] m_vram  [PAGES][COLS];
  bit         m_known [PAGES][COLS];
  logic [7:0] cmd_q[$];
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_start, m_offset, m_contrast;
  bit m_seg, m_com, m_inv, m_all, m_disp;

  task automatic check_val(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_mode = 2; m_start = 0; m_offset = 0; m_contrast = 'h7F;
    m_seg = 0; m_com = 0; m_inv = 0; m_all = 0; m_disp = 0;
    cmd_q.delete();
  endtask

  function automatic int nargs(input logic [7:0] op);
    case (op)
      8'h21, 8'h22, 8'h26, 8'h27, 8'h29, 8'h2A, 8'hA3:               return 2;
      8'h20, 8'h81, 8'hD3, 8'hA8, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: return 1;
      default:                                                        return 0;
    endcase
  endfunction

  task automatic model_apply();
    int op = int'(cmd_q[0]);
    int a1 = (cmd_q.size() > 1) ? int'(cmd_q[1]) : 0;
    int a2 = (cmd_q.size() > 2) ? int'(cmd_q[2]) : 0;
    if (op == 'h21) begin m_cs = a1 % COLS; m_ce = a2 % COLS; m_col = m_cs; end
    else if (op == 'h22) begin m_ps = a1 % PAGES; m_pe = a2 % PAGES; m_page = m_ps; end
    else if (op == 'h20) begin if (a1 % 4 != 3) m_mode = a1 % 4; end
    else if (op == 'h81) m_contrast = a1;
    else if (op == 'hD3) m_offset = a1 % ROWS;
    else if (nargs(cmd_q[0]) != 0) ;
    else if (op < 'h10) m_col = (m_col / 16) * 16 + op;
    else if (op < 'h20) m_col = ((op - 'h10) * 16 + m_col % 16) % COLS;
    else if (op >= 'hB0 && op <= 'hB7) m_page = (op - 'hB0) % PAGES;
    else if (op >= 'h40 && op <= 'h7F) m_start = (op - 'h40) % ROWS;
    else if (op == 'hA0 || op == 'hA1) m_seg  = (op == 'hA1);
    else if (op == 'hA4 || op == 'hA5) m_all  = (op == 'hA5);
    else if (op == 'hA6 || op == 'hA7) m_inv  = (op == 'hA7);
    else if (op == 'hAE || op == 'hAF) m_disp = (op == 'hAF);
    else if (op == 'hC0 || op == 'hC8) m_com  = (op == 'hC8);
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] d);
    if (dc) begin
      cmd_q.delete();
      m_vram[m_page][m_col]  = d;
      m_known[m_page][m_col] = 1'b1;
      case (m_mode)
        0: if (m_col == m_ce) begin
             m_col = m_cs;
             m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
           end else m_col = (m_col + 1) % COLS;
        1: if (m_page == m_pe) begin
             m_page = m_ps;
             m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
           end else m_page = (m_page + 1) % PAGES;
        default: m_col = (m_col + 1) % COLS;
      endcase
    end else begin
      cmd_q.push_back(d);
      if (cmd_q.size() == 1 + nargs(cmd_q[0])) begin
        model_apply();
        cmd_q.delete();
      end
    end
  endtask

  function automatic void model_pixel(input int c, input int r, output bit val, output bit known);
    int pc = m_seg ? COLS - 1 - c : c;
    int rr = (r + m_start + m_offset) % ROWS;
    int pr = m_com ? ROWS - 1 - rr : rr;
    if (!m_disp) begin val = 1'b0; known = 1'b1; end
    else if (m_all) begin val = 1'b1; known = 1'b1; end
    else begin
      known = m_known[pr / 8][pc];
      val   = m_vram[pr / 8][pc][pr % 8] ^ m_inv;
    end
  endfunction

  // Compare process: expectation taken at the sampling edge, checked half a cycle later
  bit exp_pix_q, exp_valid_q;
  always @(posedge clk) begin : cmp_sample
    bit v, k;
    model_pixel(int'(rd_col), int'(rd_row), v, k);
    exp_pix_q   <= v;
    exp_valid_q <= k && rd_check_en && !rst;
  end

  always @(negedge clk) begin
    if (exp_valid_q) check_val("rd_pixel_model", int'(rd_pixel), int'(exp_pix_q));
    if (!rst) begin
      check_val("disp_on_model", int'(disp_on), int'(m_disp));
      check_val("contrast_model", int'(contrast), m_contrast);
    end
  end

  task automatic send_byte(input bit dc, input logic [7:0] d);
    int waited = 0;
    rd_check_en = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check_val("in_ready_wait", int'(bus.in_ready), 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_dc    = dc;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_byte(dc, d);
    @(negedge clk);
    check_val("in_ready_gap", int'(bus.in_ready), 0);
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d); send_byte(1'b0, d); endtask
  task automatic dat(input logic [7:0] d); send_byte(1'b1, d); endtask

  task automatic read_pixel(input int c, input int r, output bit v);
    @(negedge clk);
    rd_col = 7'(c);
    rd_row = 6'(r);
    rd_check_en = 1'b1;
    @(negedge clk);
    v = rd_pixel;
  endtask

  task automatic expect_pix(input string name, input int c, input int r, input int exp);
    bit v;
    read_pixel(c, r, v);
    check_val(name, int'(v), exp);
  endtask

  // Assumes no remap/scroll/invert/all-on and display on
  task automatic expect_byte(input string name, input int page, input int col, input int exp);
    bit v;
    int b = 0;
    for (int i = 0; i < 8; i++) begin
      read_pixel(col, page * 8 + i, v);
      b |= int'(v) << i;
    end
    check_val(name, b, exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_dc    = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", int'(bus.in_ready), 0);
    check_val("rst_rd_pixel", int'(rd_pixel), 0);
    check_val("rst_disp_on", int'(disp_on), 0);
    check_val("rst_contrast", int'(contrast), 'h7F);
    rst = 1'b0;

    // Horizontal mode inside a 2x2 window with wrap
    cmd('hAF); cmd('h20); cmd('h00);
    cmd('h21); cmd('h10); cmd('h11);
    cmd('h22); cmd('h02); cmd('h03);
    dat('hAA); dat('hBB); dat('hCC); dat('hDD); dat('hEE);
    check_val("model_h_2_16", int'(m_vram[2][16]), 'hEE);
    check_val("model_h_3_17", int'(m_vram[3][17]), 'hDD);
    expect_byte("horiz_2_16", 2, 16, 'hEE);
    expect_byte("horiz_2_17", 2, 17, 'hBB);
    expect_byte("horiz_3_16", 3, 16, 'hCC);
    expect_byte("horiz_3_17", 3, 17, 'hDD);

    // Page mode column wrap, page pointer stays
    cmd('h20); cmd('h02);
    cmd('hB5); cmd('h0F); cmd('h17);
    dat('h12); dat('h34); dat('h56);
    check_val("model_p_5_0", int'(m_vram[5][0]), 'h34);
    expect_byte("page_5_7f", 5, 127, 'h12);
    expect_byte("page_5_00", 5, 0, 'h34);
    expect_byte("page_5_01", 5, 1, 'h56);

    // Data byte abandons a pending contrast command
    cmd('h81); dat('h55);
    check_val("contrast_abandon", int'(contrast), 'h7F);
    expect_byte("abandon_data", 5, 2, 'h55);
    cmd('h81); cmd('h30);
    check_val("contrast_set", int'(contrast), 'h30);

    // Invert, segment remap and COM direction
    cmd('hB0); cmd('h00); cmd('h10); dat('h01);
    expect_pix("pix_0_0", 0, 0, 1);
    cmd('hA7);
    expect_pix("pix_invert", 0, 0, 0);
    cmd('hA1); cmd('hC8);
    expect_pix("pix_remap_inv", 127, 63, 0);
    cmd('hA6);
    expect_pix("pix_remap", 127, 63, 1);
    cmd('hA0); cmd('hC0);

    // Start line and display offset wrap modulo ROWS
    cmd('h41);
    expect_pix("pix_start_wrap", 0, 63, 1);
    cmd('hD3); cmd('h3F);
    expect_pix("pix_offset_wrap", 0, 0, 1);
    cmd('h40); cmd('hD3); cmd('h00);

    // All-on and display off
    cmd('hA5);
    expect_pix("pix_all_on", 50, 40, 1);
    cmd('hA4); cmd('hAE);
    expect_pix("pix_disp_off", 0, 0, 0);
    check_val("disp_off", int'(disp_on), 0);
    cmd('hAF);

    // Vertical mode; mode argument 3 is ignored
    cmd('h20); cmd('h01);
    cmd('h21); cmd('h20); cmd('h21);
    cmd('h22); cmd('h06); cmd('h07);
    dat('h61); dat('h62); dat('h63); dat('h64);
    cmd('h20); cmd('h03);
    dat('h65); dat('h66);
    expect_byte("vert_6_32", 6, 32, 'h65);
    expect_byte("vert_7_32", 7, 32, 'h66);
    expect_byte("vert_6_33", 6, 33, 'h63);
    expect_byte("vert_7_33", 7, 33, 'h64);

    // Reset between 0x22 and its argument
    cmd('h22);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_val("midcmd_disp_on", int'(disp_on), 0);
    check_val("midcmd_contrast", int'(contrast), 'h7F);
    cmd('hAF); cmd('h03); dat('h99);
    expect_byte("midcmd_col_nibble", 0, 3, 'h99);
    cmd('h20); cmd('h00); cmd('hB0);
    cmd('h21); cmd('h7E); cmd('h7E);
    dat('hA1); dat('hA2);
    expect_byte("page_end_0_7e", 0, 126, 'hA1);
    expect_byte("page_end_1_7e", 1, 126, 'hA2);

    rd_check_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd13xx_gfx_ctrl.md
SSD13XX_GFX_CTRL -- requirements
Module: ssd13xx_gfx_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 128: panel columns (power of 2, 64..256).
REQ-002 SHALL have parameter ROWS, default 64: panel rows (32 or 64); PAGES = ROWS/8.
REQ-003 SHALL have parameter VRAM_STYLE, default "block": synthesis hint for VRAM.
REQ-004 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-005 SHALL have ports, as name direction width meaning:
- clk in 1: single clock for all logic.
- rst in 1: async reset, active-high.
- in_valid in 1: command/data byte offered.
- in_ready out 1: byte accepted when in_valid and in_ready.
- in_dc in 1: 1 = display data, 0 = command/argument.
- in_data in 8: byte value.
- rd_col in log2(COLS): raster column request.
- rd_row in log2(ROWS): raster row request.
- rd_pixel out 1: pixel for the request one cycle earlier.
- disp_on out 1: display on.
- contrast out 8: last contrast argument.

Function
REQ-006 SHALL have a command FSM with states IDLE, ARG1 and ARG2; an opcode in IDLE selects the arg count (0, 1 or 2).
REQ-007 SHALL treat two-argument opcodes as 0x21 col start/end, 0x22 page start/end, and 0x26/0x27/0x29/0x2A/0xA3 (scroll commands, args consumed and ignored).
REQ-008 SHALL treat one-argument opcodes as 0x20 mode, 0x81 contrast and 0xD3 offset, plus 0xA8/0xD5/0xD9/0xDA/0xDB/0x8D, which are consumed and ignored.
REQ-009 SHALL apply single-byte commands as follows; other opcodes are ignored:
- 0x00-0x0F: col low nibble.
- 0x10-0x1F: col high nibble.
- 0xB0-0xB7: page pointer.
- 0x40-0x7F: start line.
- A0/A1: seg remap.
- C0/C8: COM scan dir.
- A4/A5: all-on off/on.
- A6/A7: invert off/on.
- AE/AF: disp_on off/on.
REQ-010 SHALL apply a command only when its last argument is accepted.
REQ-011 SHALL, on a data byte accepted while in ARG1/ARG2, abandon the pending command, return to IDLE and write the byte.
REQ-012 SHALL mask column arguments to log2(COLS) bits and page arguments to log2(PAGES) bits.
REQ-013 SHALL ignore mode argument 0b11 and keep the previous mode.
REQ-014 SHALL write a data byte to VRAM[page][col] one cycle after acceptance, then advance the pointer per mode:
- Horizontal: col==col_end -> col=col_start, and page advances (page==page_end -> page_start); else col+1.
- Vertical: page==page_end -> page=page_start, and col advances (col==col_end -> col_start); else page+1.
- Page: col==COLS-1 -> col=0, page unchanged; else col+1.
REQ-015 SHALL load the pointers to col_start and page_start when a 0x21 or 0x22 command completes.
REQ-016 SHALL drive in_ready low during reset and for the one cycle after each accepted byte (max 1 byte per 2 cycles).
REQ-017 SHALL map rd_col/rd_row to physical coordinates as follows:
- pc = seg_remap ? COLS-1-rd_col : rd_col.
- r = (rd_row + start_line + offset) mod ROWS.
- pr = com_dec ? ROWS-1-r : r.
REQ-018 SHALL register rd_pixel = disp_on & (all_on | (VRAM[pr/8][pc] bit pr%8 ^ invert)), with a latency of exactly 1 cycle.
REQ-019 SHALL return the old VRAM data when a read and a write hit the same byte in the same cycle.

Reset
REQ-020 SHALL reset to the following values; VRAM contents are not reset:
- FSM: IDLE.
- in_ready: 0.
- col/page pointers: 0.
- col_start: 0; col_end: COLS-1.
- page_start: 0; page_end: PAGES-1.
- mode: page.
- disp_on: 0.
- contrast: 0x7F.
- start_line, offset, seg_remap, com_dec, invert, all_on: 0.
- rd_pixel: 0.
REQ-021 SHALL, on reset asserted mid-command or mid-write, discard the pending argument and the write.

Structure
REQ-022 SHALL place the opcode constants, argument-count table and mode encodings in shared package ssd13xx_pkg.
REQ-023 SHALL implement VRAM as sub-module ssd13xx_vram: simple dual-port, COLS*PAGES bytes, registered read.

Verification
REQ-024 SHALL pass: horizontal mode, 0x21 0x10 0x11, 0x22 0x02 0x03, then data AA,BB,CC,DD,EE -> VRAM[2][16]=AA, [2][17]=BB, [3][16]=CC, [3][17]=DD, [2][16]=EE (wrap).
REQ-025 SHALL pass: page mode, 0xB5 0x0F 0x17, then 2 bytes -> written to [5][0x7F] and [5][0x00], page stays 5.
REQ-026 SHALL pass: 0x81 then a data byte 0x55 -> contrast unchanged at 0x7F, 0x55 written, FSM in IDLE.
REQ-027 SHALL pass: VRAM[0][0]=0x01, AF, read (0,0) -> rd_pixel=1 next cycle; after A7 -> 0; after A1 + C8, read (COLS-1,ROWS-1) -> 0 again.
REQ-028 SHALL pass: 0x41 + AF, read row 63 -> data from physical row 0 (mod ROWS wrap).
REQ-029 SHALL pass: rst pulsed between 0x22 and its first argument -> FSM IDLE, page_end=PAGES-1, next byte 0x03 decoded as col low nibble.
